mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_rr_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding, port indices and data-memory address map used by the
// arbiter, the memory and the CPU address decode.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Memory-mapped I/O window at the top of the data memory
  localparam int unsigned ADDR_IO_LO     = 121;
  localparam int unsigned ADDR_UART_FLAG = 121;
  localparam int unsigned ADDR_UART_DATA = 122;
  localparam int unsigned ADDR_SEVEN_SEG = 127;
  localparam int unsigned ADDR_IO_HI     = 127;
  localparam int unsigned WP_LIMIT       = 24;

  function automatic logic is_io_addr(input logic [15:0] addr);
    return (32'(addr) >= ADDR_IO_LO) && (32'(addr) <= ADDR_IO_HI);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the port that was not granted last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = PORT_A;
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end else if (req_i[PORT_B]) begin
      grant_o = PORT_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (port A) and loader/DMA (port B) accesses onto the single-port
// data memory; the memory address is parked at IDLE_ADDR between accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                    WORD_SIZE  = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WORD_SIZE-1:0]  a_wdata,
  output logic                  a_ack,
  output logic [WORD_SIZE-1:0]  a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WORD_SIZE-1:0]  b_wdata,
  output logic                  b_ack,
  output logic [WORD_SIZE-1:0]  b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_data_in,
  output logic                  mem_write,
  input  logic [WORD_SIZE-1:0]  mem_data_out,
  output logic                  busy
);

  arb_state_e            state_q;
  logic                  last_grant_q;
  logic                  grant_q;
  logic                  a_ack_q, b_ack_q;
  logic [WORD_SIZE-1:0]  a_rdata_q, b_rdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0]  mem_data_in_q;
  logic                  mem_write_q;
  logic                  busy_q;

  logic                  pick_valid_d;
  logic                  grant_d;
  logic [ADDR_WIDTH-1:0] pick_addr_d;
  logic [WORD_SIZE-1:0]  pick_wdata_d;
  logic                  pick_we_d;

  rr_pick2 u_pick (
    .req_i        ({b_req, a_req}),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid_d),
    .grant_o      (grant_d)
  );

  always_comb begin
    pick_addr_d  = a_addr;
    pick_wdata_d = a_wdata;
    pick_we_d    = a_we;
    if (grant_d == PORT_B) begin
      pick_addr_d  = b_addr;
      pick_wdata_d = b_wdata;
      pick_we_d    = b_we;
    end
  end

  // The memory-side registers double as the latched request, so requester
  // inputs are ignored once a grant has been taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= PORT_B;
      grant_q       <= PORT_A;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      mem_addr_q    <= IDLE_ADDR;
      mem_data_in_q <= '0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_d) begin
            grant_q       <= grant_d;
            last_grant_q  <= grant_d;
            mem_addr_q    <= pick_addr_d;
            mem_data_in_q <= pick_wdata_d;
            mem_write_q   <= pick_we_d;
            busy_q        <= 1'b1;
            state_q       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (grant_q == PORT_B) begin
            b_rdata_q <= mem_data_out;
          end else begin
            a_rdata_q <= mem_data_out;
          end
          a_ack_q       <= (grant_q == PORT_A);
          b_ack_q       <= (grant_q == PORT_B);
          mem_addr_q    <= IDLE_ADDR;
          mem_data_in_q <= '0;
          mem_write_q   <= 1'b0;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_write   = mem_write_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus two randomized requesters
// checked against a word-level reference memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [15:0] IDLE_ADDR = 16'd0;
  localparam int RAND_TXNS = 40;

  logic        clk, rst;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_write, busy;

  int assertCount = 0;
  int failCount = 0;
  int cycle = 0;
  bit monitorOn = 0;

  logic [15:0] envMem [0:255];
  logic [15:0] refMem [0:255];
  bit          envInit = 0;
  bit          tbWe = 0;
  logic [7:0]  tbAddr = '0;
  logic [15:0] tbData = '0;

  mem_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(16), .IDLE_ADDR(IDLE_ADDR)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [15:0] initWord(input int i);
    return 16'hC300 | 16'(i & 255);
  endfunction

  // Environment memory: protected low words, and any read cycle on the UART
  // data word clears the UART flag.
  always @(posedge clk) begin
    if (envInit) begin
      for (int i = 0; i < 256; i++) envMem[i] <= initWord(i);
    end else begin
      if (tbWe) envMem[tbAddr] <= tbData;
      if (mem_write && 32'(mem_addr) > WP_LIMIT)
        envMem[mem_addr[7:0]] <= mem_data_in;
      else if (!mem_write && 32'(mem_addr) == ADDR_UART_DATA)
        envMem[8'(ADDR_UART_FLAG)] <= 16'h0000;
    end
  end
  assign mem_data_out = envMem[mem_addr[7:0]];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge; req is dropped after
  // the ack cycle unless the caller immediately issues another request.
  task automatic applyStimulus(input bit port, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata, output logic [15:0] rdata,
                               output int lat, output int ackCycle);
    logic ackSeen;
    string tag;
    if (port) begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; tag = "bAckTimeout"; end
    else      begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; tag = "aAckTimeout"; end
    lat = 0;
    rdata = '0;
    ackCycle = 0;
    forever begin
      @(negedge clk);
      ackSeen = port ? b_ack : a_ack;
      if (ackSeen) break;
      lat++;
      if (lat > 20) begin
        checkOutput(tag, 32'(ackSeen), 32'd1);
        break;
      end
    end
    rdata = port ? b_rdata : a_rdata;
    ackCycle = cycle;
    @(posedge clk); #1;
    if (port) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic loadEnv(input logic [7:0] addr, input logic [15:0] data);
    tbWe = 1'b1; tbAddr = addr; tbData = data;
    @(posedge clk); #1;
    tbWe = 1'b0;
  endtask

  always @(negedge clk) begin
    if (monitorOn && !rst) begin
      if (!busy) begin
        checkOutput("idleParkAddr", 32'(mem_addr), 32'(IDLE_ADDR));
        checkOutput("idleNoWrite", 32'(mem_write), 32'd0);
      end
      if (a_ack || b_ack) begin
        checkOutput("ackBusy", 32'(busy), 32'd1);
        checkOutput("ackParkAddr", 32'(mem_addr), 32'(IDLE_ADDR));
      end
      checkOutput("ackExclusive", 32'(a_ack & b_ack), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    int lat, ac, base;
    rst = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

    resetDut();
    envInit = 1'b1;
    @(posedge clk); #1;
    envInit = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstMemAddr", 32'(mem_addr), 32'(IDLE_ADDR));
    checkOutput("rstMemWrite", 32'(mem_write), 0);
    checkOutput("rstMemData", 32'(mem_data_in), 0);
    checkOutput("rstAcks", 32'({a_ack, b_ack}), 0);
    checkOutput("rstRdata", 32'({a_rdata, b_rdata}), 0);
    @(posedge clk); #1;
    monitorOn = 1'b1;

    $display("[TB] single A write then read");
    a_we = 1; a_addr = 16'h0040; a_wdata = 16'hBEEF; a_req = 1;
    @(negedge clk);
    checkOutput("t1C0Write", 32'(mem_write), 0);
    @(negedge clk);
    checkOutput("t1C1Write", 32'(mem_write), 1);
    checkOutput("t1C1Addr", 32'(mem_addr), 32'h40);
    checkOutput("t1C1Data", 32'(mem_data_in), 32'hBEEF);
    checkOutput("t1C1Ack", 32'(a_ack), 0);
    @(negedge clk);
    checkOutput("t1C2Ack", 32'(a_ack), 1);
    checkOutput("t1C2Write", 32'(mem_write), 0);
    @(posedge clk); #1;
    a_req = 0;
    applyStimulus(0, 0, 16'h0040, 16'h0, rd, lat, ac);
    checkOutput("t1ReadBack", 32'(rd), 32'hBEEF);
    checkOutput("t1ReadLat", 32'(lat), 2);

    $display("[TB] simultaneous requests from reset");
    resetDut();
    fork
      begin
        logic [15:0] rdA; int latA, acA;
        applyStimulus(0, 0, 16'h0050, 16'h0, rdA, latA, acA);
        checkOutput("t2ALat", 32'(latA), 2);
        checkOutput("t2AOld", 32'(rdA), 32'(initWord(16'h50)));
      end
      begin
        logic [15:0] rdB; int latB, acB;
        applyStimulus(1, 1, 16'h0050, 16'h1234, rdB, latB, acB);
        checkOutput("t2BLat", 32'(latB), 5);
      end
    join
    applyStimulus(0, 0, 16'h0050, 16'h0, rd, lat, ac);
    checkOutput("t2ReRead", 32'(rd), 32'h1234);

    $display("[TB] fairness with both ports saturated");
    resetDut();
    base = cycle;
    fork
      for (int i = 0; i < 3; i++) begin
        logic [15:0] rdA; int latA, acA;
        applyStimulus(0, 0, 16'h0030, 16'h0, rdA, latA, acA);
        checkOutput("t3AckA", 32'(acA - base), 32'(2 + 6 * i));
      end
      for (int i = 0; i < 3; i++) begin
        logic [15:0] rdB; int latB, acB;
        applyStimulus(1, 0, 16'h0031, 16'h0, rdB, latB, acB);
        checkOutput("t3AckB", 32'(acB - base), 32'(5 + 6 * i));
      end
    join

    $display("[TB] idle address parking");
    loadEnv(8'(ADDR_UART_DATA), 16'h0041);
    loadEnv(8'(ADDR_UART_FLAG), 16'h0001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t4ParkAddr", 32'(mem_addr), 32'(IDLE_ADDR));
    end
    @(posedge clk); #1;
    applyStimulus(1, 0, 16'(ADDR_UART_FLAG), 16'h0, rd, lat, ac);
    checkOutput("t4FlagKept", 32'(rd), 32'h1);

    $display("[TB] reset during ACCESS");
    resetDut();
    a_we = 1; a_addr = 16'h0060; a_wdata = 16'h00AA; a_req = 1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5InAccess", 32'(mem_write), 1);
    @(posedge clk); #1;
    rst = 1'b0; a_req = 0;
    @(negedge clk);
    checkOutput("t5NoAck", 32'(a_ack), 0);
    checkOutput("t5Busy", 32'(busy), 0);
    checkOutput("t5Write", 32'(mem_write), 0);
    checkOutput("t5Addr", 32'(mem_addr), 32'(IDLE_ADDR));
    checkOutput("t5Rdata", 32'(a_rdata), 0);
    @(negedge clk);
    checkOutput("t5NoLateAck", 32'(a_ack), 0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 16'h0060, 16'h0, rd, lat, ac);
    checkOutput("t5Committed", 32'(rd), 32'h00AA);

    $display("[TB] write to protected address");
    resetDut();
    applyStimulus(1, 1, 16'h0010, 16'h7777, rd, lat, ac);
    checkOutput("t6AckLat", 32'(lat), 2);
    applyStimulus(1, 0, 16'h0010, 16'h0, rd, lat, ac);
    checkOutput("t6Unchanged", 32'(rd), 32'(initWord(16'h10)));

    $display("[TB] randomized traffic on both ports");
    envInit = 1'b1;
    @(posedge clk); #1;
    envInit = 1'b0;
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    fork
      for (int i = 0; i < RAND_TXNS; i++) begin
        logic [15:0] rdA, adA, wdA; int latA, acA, gapA; bit weA;
        gapA = int'($urandom_range(0, 2));
        repeat (gapA) begin @(posedge clk); #1; end
        weA = 1'($urandom_range(0, 1));
        adA = 16'($urandom_range(0, 120));
        wdA = 16'($urandom);
        applyStimulus(0, weA, adA, wdA, rdA, latA, acA);
        if (!weA) checkOutput("randReadA", 32'(rdA), 32'(refMem[adA[7:0]]));
        else if (32'(adA) > WP_LIMIT) refMem[adA[7:0]] = wdA;
        checkOutput("randLatA", 32'(latA >= 2 && latA <= 5), 1);
      end
      for (int i = 0; i < RAND_TXNS; i++) begin
        logic [15:0] rdB, adB, wdB; int latB, acB, gapB; bit weB;
        gapB = int'($urandom_range(0, 2));
        repeat (gapB) begin @(posedge clk); #1; end
        weB = 1'($urandom_range(0, 1));
        adB = 16'($urandom_range(0, 120));
        wdB = 16'($urandom);
        applyStimulus(1, weB, adB, wdB, rdB, latB, acB);
        if (!weB) checkOutput("randReadB", 32'(rdB), 32'(refMem[adB[7:0]]));
        else if (32'(adB) > WP_LIMIT) refMem[adB[7:0]] = wdB;
        checkOutput("randLatB", 32'(latB >= 2 && latB <= 5), 1);
      end
    join

    repeat (3) @(posedge clk);
    monitorOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
